// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter (SRL, plus SRA when SEQ_SHIFT_RIGHT_SRA_EN is defined),
// shifting up to STEP bits per cycle behind valid/ready handshakes.
module seq_shift_right #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_srl,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   out_srl_q, out_srl_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] shamt_in;

  assign shamt_in = in_2[SHAMT_W-1:0];

`ifdef SEQ_SHIFT_RIGHT_SRA_EN
  logic mode_q, mode_d;
  logic unused_in_2_hi;
  assign unused_in_2_hi = ^in_2[WIDTH-1:SHAMT_W];
`else
  logic unused_ignored;
  assign unused_ignored = ^{in_2[WIDTH-1:SHAMT_W], arith};
`endif

  always_comb begin
    k = (rem_q > SHAMT_W'(STEP)) ? SHAMT_W'(STEP) : rem_q;
`ifdef SEQ_SHIFT_RIGHT_SRA_EN
    shifted = mode_q ? $unsigned($signed(op_q) >>> k) : (op_q >> k);
`else
    shifted = op_q >> k;
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    out_srl_d = out_srl_q;
`ifdef SEQ_SHIFT_RIGHT_SRA_EN
    mode_d    = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = in_1;
          rem_d = shamt_in;
`ifdef SEQ_SHIFT_RIGHT_SRA_EN
          mode_d = arith;
`endif
          if (shamt_in == '0) begin
            state_d   = DONE;
            out_srl_d = in_1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        op_d  = shifted;
        rem_d = rem_q - k;
        if (rem_q == k) begin
          state_d   = DONE;
          out_srl_d = shifted;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered, so derive them from the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rem_q       <= '0;
      out_srl_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_SHIFT_RIGHT_SRA_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      out_srl_q   <= out_srl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SEQ_SHIFT_RIGHT_SRA_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_srl   = out_srl_q;
  assign busy      = busy_q;

endmodule
